addsub_arbiter: RTL and testbench



---
 rtl/addsub_ctrl_pkg.sv | 38 +++
 rtl/addsub_16bit.sv | 45 ++++
 rtl/addsub_arbiter.sv | 132 +++++++++++++
 tb/tb_addsub_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_ctrl_pkg.sv
// Shared encodings for the addsub arbiter: opcodes, FSM states and the
// adder control bundle decoded from an opcode.
package addsub_ctrl_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10,
    OP_RED    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic padd;
    logic red;
    logic sub;
  } ctrl_t;

  function automatic ctrl_t decode_op(input op_e op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_SUB:    c.sub  = 1'b1;
      OP_PADDSB: c.padd = 1'b1;
      OP_RED:    c.red  = 1'b1;
      default:   c      = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_16bit.sv
// Saturating 16-bit add/sub, parallel signed-nibble saturating add and a
// signed byte-sum reduction saturated to 8 bits and sign-extended.
module addsub_16bit
  import addsub_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             padd_i,
  input  logic             red_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] s_o
);

  logic [15:0] b_eff;
  logic [16:0] wide_sum;
  logic [15:0] full_sat;
  logic [15:0] nib_sat;
  logic [9:0]  red_sum;
  logic [7:0]  red_sat;

  // Subtraction is a + ~b + 1 evaluated one bit wider so overflow is visible.
  assign b_eff    = sub_i ? ~b_i : b_i;
  assign wide_sum = {a_i[15], a_i} + {b_eff[15], b_eff} + {16'd0, sub_i};
  assign full_sat = (wide_sum[16] != wide_sum[15])
                  ? (wide_sum[16] ? 16'h8000 : 16'h7FFF)
                  : wide_sum[15:0];

  for (genvar g = 0; g < 4; g++) begin : g_nib
    logic [4:0] nib_sum;
    assign nib_sum = {a_i[4*g+3], a_i[4*g +: 4]} + {b_i[4*g+3], b_i[4*g +: 4]};
    assign nib_sat[4*g +: 4] = (nib_sum[4] != nib_sum[3])
                             ? (nib_sum[4] ? 4'h8 : 4'h7)
                             : nib_sum[3:0];
  end

  assign red_sum = {{2{a_i[7]}},  a_i[7:0]}  + {{2{a_i[15]}}, a_i[15:8]}
                 + {{2{b_i[7]}},  b_i[7:0]}  + {{2{b_i[15]}}, b_i[15:8]};
  assign red_sat = (red_sum[9:7] == 3'b000 || red_sum[9:7] == 3'b111)
                 ? red_sum[7:0]
                 : (red_sum[9] ? 8'h80 : 8'h7F);

  assign s_o = red_i  ? {{8{red_sat[7]}}, red_sat} :
               padd_i ? nib_sat : full_sat;

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one addsub_16bit between two requesters, with
// registered operands/result and a valid/ready response per requester.
module addsub_arbiter
  import addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = addsub_ctrl_pkg::WIDTH,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [NREQ-1:0]  valid_vec;
  logic             grant;
  logic             accept;
  logic             own_rsp_ready;
  logic [WIDTH-1:0] adder_s;
  ctrl_t            ctrl;

  assign valid_vec = {req1_valid, req0_valid};

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    grant = rr_ptr_q;
    case (valid_vec)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = rr_ptr_q;
    endcase
  end

  assign req0_ready    = !rst && (state_q == ST_IDLE) && !grant && req0_valid;
  assign req1_ready    = !rst && (state_q == ST_IDLE) &&  grant && req1_valid;
  assign accept        = req0_ready || req1_ready;
  assign own_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  assign ctrl = decode_op(op_q);

  addsub_16bit u_addsub (
    .a_i    (a_q),
    .b_i    (b_q),
    .padd_i (ctrl.padd),
    .red_i  (ctrl.red),
    .sub_i  (ctrl.sub),
    .s_o    (adder_s)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d  = grant;
          rr_ptr_d = ~grant;
          op_d     = op_e'(grant ? req1_op : req0_op);
          a_d      = grant ? req1_a : req0_a;
          b_d      = grant ? req1_b : req0_b;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = adder_s;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (own_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_data  = rsp0_valid ? result_q : '0;
  assign rsp1_data  = rsp1_valid ? result_q : '0;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a transaction-level reference model
// compared against the DUT on every negative clock edge.
module tb_addsub_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0][1:0]  req_op = '0;
  logic [1:0][15:0] req_a = '0;
  logic [1:0][15:0] req_b = '0;
  logic [1:0]       rsp_ready = '0;
  wire  [1:0]       req_ready;
  wire  [1:0]       rsp_valid;
  wire  [15:0]      rsp0_data, rsp1_data;
  wire              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_op    (req_op[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp0_data),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_op    (req_op[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp1_data),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Expected arithmetic written directly from the operation definitions.
  function automatic logic [15:0] exp_result(input logic [1:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    int s;
    logic [15:0] r;
    logic [31:0] t;
    r = '0;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b00) ? int'($signed(a)) + int'($signed(b))
                          : int'($signed(a)) - int'($signed(b));
        t = clamp(s, -32768, 32767);
        r = t[15:0];
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          s = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
          t = clamp(s, -8, 7);
          r[4*i +: 4] = t[3:0];
        end
      end
      default: begin
        s = 0;
        for (int i = 0; i < 2; i++)
          s += int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
        t = clamp(s, -128, 127);
        r = t[15:0];
      end
    endcase
    return r;
  endfunction

  // Reference model: idle/age-of-operation tracking updated on each edge.
  bit          model_on = 1'b0;
  bit          m_busy   = 1'b0;
  int          m_age    = 0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  logic [15:0] m_res    = '0;

  function automatic int model_grant();
    if (req_valid == 2'b01) return 0;
    if (req_valid == 2'b10) return 1;
    return m_ptr;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        g       = model_grant();
        m_owner = g;
        m_ptr   = 1 - g;
        m_res   = exp_result(req_op[g], req_a[g], req_b[g]);
        m_busy  = 1'b1;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready[m_owner]) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic        e_ready, e_valid;
    logic [15:0] e_data;
    if (model_on) begin
      check("busy", busy, m_busy);
      for (int n = 0; n < 2; n++) begin
        e_ready = !rst && !m_busy && req_valid[n] && (model_grant() == n);
        e_valid = m_busy && (m_age == 2) && (m_owner == n);
        e_data  = e_valid ? m_res : 16'h0000;
        check($sformatf("req%0d_ready", n), req_ready[n], e_ready);
        check($sformatf("rsp%0d_valid", n), rsp_valid[n], e_valid);
        check($sformatf("rsp%0d_data", n), (n == 0) ? rsp0_data : rsp1_data, e_data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  // One isolated operation on requester n with its response always accepted.
  task automatic run_op(input int n, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input string name);
    bit got = 1'b0;
    req_op[n] = op; req_a[n] = a; req_b[n] = b;
    req_valid[n] = 1'b1;
    rsp_ready[n] = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req_ready[n]) got = 1'b1;
      else next_cycle();
    end
    check({name, "_accept"}, got, 1);
    next_cycle();
    req_valid[n] = 1'b0;
    if (!got) return;
    @(negedge clk);
    check({name, "_exec_novalid"}, rsp_valid[n], 0);
    next_cycle();
    @(negedge clk);
    check({name, "_valid_t2"}, rsp_valid[n], 1);
    check({name, "_other_idle"}, rsp_valid[1-n], 0);
    check({name, "_data"}, (n == 0) ? rsp0_data : rsp1_data, exp);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int acc_who[$];
    int acc_cyc[$];

    check("model_add_sat", exp_result(2'b00, 16'h7000, 16'h2000), 16'h7FFF);
    check("model_sub_sat", exp_result(2'b01, 16'h8000, 16'h0001), 16'h8000);
    check("model_paddsb",  exp_result(2'b10, 16'h7171, 16'h1111), 16'h7272);
    check("model_paddsb_n", exp_result(2'b10, 16'h9000, 16'h9000), 16'h8000);
    check("model_red",     exp_result(2'b11, 16'h0102, 16'h0304), 16'h000A);
    check("model_red_neg", exp_result(2'b11, 16'h8080, 16'h8080), 16'hFF80);

    next_cycle();
    model_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_ready", req_ready, 2'b00);
    check("reset_rsp0_data", rsp0_data, 16'h0000);
    next_cycle();

    run_op(0, 2'b00, 16'h7000, 16'h2000, 16'h7FFF, "add_sat");
    run_op(1, 2'b01, 16'h0005, 16'h0007, 16'hFFFE, "sub");
    req_valid = 2'b11;
    @(negedge clk);
    check("rr_prefers_req0", req_ready, 2'b01);
    req_valid = 2'b00;
    next_cycle();
    run_op(0, 2'b10, 16'h7171, 16'h1111, 16'h7272, "paddsb");
    run_op(0, 2'b11, 16'h0102, 16'h0304, 16'h000A, "red");

    // Contention from reset with both responders ready.
    do_reset();
    req_op[0] = 2'b00; req_a[0] = 16'h0001; req_b[0] = 16'h0001;
    req_op[1] = 2'b01; req_a[1] = 16'h0000; req_b[1] = 16'h0001;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin acc_who.push_back(0); acc_cyc.push_back(c); end
      if (req_ready[1]) begin acc_who.push_back(1); acc_cyc.push_back(c); end
      if (rsp_valid[0]) check("cont_rsp0_data", rsp0_data, 16'h0002);
      if (rsp_valid[1]) check("cont_rsp1_data", rsp1_data, 16'hFFFF);
      next_cycle();
    end
    req_valid = 2'b00;
    check("cont_accepts", acc_who.size(), 4);
    for (int i = 0; i < acc_who.size(); i++) begin
      check($sformatf("cont_owner_%0d", i), acc_who[i], i % 2);
      check($sformatf("cont_cycle_%0d", i), acc_cyc[i], 3 * i);
    end
    next_cycle();

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    req_op[0] = 2'b00; req_a[0] = 16'h0001; req_b[0] = 16'h0002;
    req_op[1] = 2'b01; req_a[1] = 16'h000A; req_b[1] = 16'h0003;
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    check("bp_accept0", req_ready, 2'b01);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_exec_ready1", req_ready[1], 0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid[0], 1);
      check("bp_hold_data", rsp0_data, 16'h0003);
      check("bp_hold_ready1", req_ready[1], 0);
      next_cycle();
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_ready1", req_ready[1], 0);
    next_cycle();
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_req1_accept", req_ready[1], 1);
    next_cycle();
    req_valid[1] = 1'b0;
    next_cycle();
    @(negedge clk);
    check("bp_rsp1_data", rsp1_data, 16'h0007);
    next_cycle();

    // Reset while requester 1's operation is executing.
    req_op[1] = 2'b11; req_a[1] = 16'h8080; req_b[1] = 16'h8080;
    req_valid = 2'b10;
    @(negedge clk);
    check("rmid_accept1", req_ready[1], 1);
    next_cycle();
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check("rmid_exec_busy", busy, 1);
    next_cycle();
    rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check("rmid_busy", busy, 0);
    check("rmid_rsp1_valid", rsp_valid[1], 0);
    check("rmid_grant0", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    repeat (4) next_cycle();

    model_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
